// File: rtl/frac_pi_master.sv
// Register-bus initiator for the fractal unit: loads one pixel job into the
// slave's operand registers, starts it, polls status and returns found/timeout.
module frac_pi_master #(
    parameter int N        = 32,
    parameter int POLL_GAP = 2,
    parameter int POLL_MAX = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_cx,
    input  logic [N-1:0] req_cy,
    input  logic [15:0]  req_max_iter,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_found,
    output logic         rsp_timeout,
    output logic         pi_blk_sel,
    output logic [3:0]   pi_addr,
    output logic         pi_wr_en,
    output logic         pi_rd_en,
    output logic [7:0]   pi_wr_data,
    input  logic [7:0]   pi_rd_data
);

    localparam int NB       = 2 * N / 8 + 2;
    localparam int OW       = 2 * N + 16;
    localparam int IW       = $clog2(NB);
    localparam int PW       = $clog2(POLL_MAX + 1);
    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    localparam logic [3:0] CTRL_ADDR   = 4'hA;
    localparam logic [3:0] STATUS_ADDR = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GO,
        GAP,
        POLL,
        SAMPLE,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   byte_idx;
    logic [IW-1:0]   next_idx;
    logic [OW-1:0]   ops_sh;
    logic [GW-1:0]   gap_cnt;
    logic [PW-1:0]   poll_cnt;
    logic            status_done;
    logic            unused_status;

    assign next_idx      = byte_idx + IW'(1);
    assign status_done   = pi_rd_data[1] & ~pi_rd_data[0];
    assign unused_status = ^pi_rd_data[7:3];

    // Bus strobes are registered on the edge that enters the state they belong
    // to, so a state and its strobe share the same cycle on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_idx    <= '0;
            ops_sh      <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b0;
            pi_blk_sel  <= 1'b0;
            pi_addr     <= 4'h0;
            pi_wr_en    <= 1'b0;
            pi_rd_en    <= 1'b0;
            pi_wr_data  <= 8'h00;
        end else begin
            pi_wr_en   <= 1'b0;
            pi_rd_en   <= 1'b0;
            pi_blk_sel <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        ops_sh     <= {req_max_iter, req_cy, req_cx} >> 8;
                        byte_idx   <= '0;
                        poll_cnt   <= '0;
                        pi_wr_en   <= 1'b1;
                        pi_blk_sel <= 1'b1;
                        pi_addr    <= 4'h0;
                        pi_wr_data <= req_cx[7:0];
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    pi_wr_en   <= 1'b1;
                    pi_blk_sel <= 1'b1;
                    if (byte_idx == IW'(NB - 1)) begin
                        pi_addr    <= CTRL_ADDR;
                        pi_wr_data <= 8'h01;
                        state      <= GO;
                    end else begin
                        byte_idx   <= next_idx;
                        pi_addr    <= 4'(next_idx);
                        pi_wr_data <= ops_sh[7:0];
                        ops_sh     <= ops_sh >> 8;
                    end
                end
                GO: begin
                    if (POLL_GAP == 0) begin
                        pi_rd_en   <= 1'b1;
                        pi_blk_sel <= 1'b1;
                        pi_addr    <= STATUS_ADDR;
                        state      <= POLL;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LAST)) begin
                        pi_rd_en   <= 1'b1;
                        pi_blk_sel <= 1'b1;
                        pi_addr    <= STATUS_ADDR;
                        state      <= POLL;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                POLL: begin
                    poll_cnt <= poll_cnt + PW'(1);
                    state    <= SAMPLE;
                end
                SAMPLE: begin
                    // Busy-and-done together means the slave restarted; keep polling.
                    if (status_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_found   <= pi_rd_data[2];
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (poll_cnt == PW'(POLL_MAX)) begin
                        rsp_valid   <= 1'b1;
                        rsp_found   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else if (POLL_GAP == 0) begin
                        pi_rd_en   <= 1'b1;
                        pi_blk_sel <= 1'b1;
                        pi_addr    <= STATUS_ADDR;
                        state      <= POLL;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
